controlador_periodo: RTL and testbench
======================================

# controlador_periodo

Controller that sequences square-wave period measurement. It arms on a start request, waits for the first rising-edge pulse from the edge detector, and counts microsecond ticks between successive edges. It optionally averages several periods and presents the result through a valid/ack handshake. It sits between the edge detector and the display/readout logic, and owns the µs timebase.

## Interface
- TICK_DIV, 50: clock_FPGA cycles per µs tick (50 MHz clock).
- CNT_W, 24: width of period count and result, in µs.
- N_PER_LOG2, 2: log2 of the number of periods averaged (used only with averaging compiled in).
- TIMEOUT_US, 1000000: µs without an edge before the measurement is aborted.

Ports:
- clock_FPGA  in  1  system clock.
- reset  in  1  reset, asynchronous, active-low.
- flanco_pos  in  1  single-cycle rising-edge pulse, synchronous to clock_FPGA.
- iniciar  in  1  start request pulse.
- ack  in  1  consumer acknowledges the result.
- periodo_us  out  CNT_W  measured (average) period in µs.
- periodo_valido  out  1  result available; held until ack.
- timeout_err  out  1  qualifies the result as a timeout; valid with periodo_valido.
- ocupado  out  1  high in ARMADO and MIDIENDO.

## Operation
- FSM states:
  - REPOSO: waits for iniciar; goes to ARMADO.
  - ARMADO: waits for flanco_pos; goes to MIDIENDO and clears the tick prescaler, period counter and accumulator.
  - MIDIENDO: counts µs ticks; each flanco_pos closes one period.
  - LISTO: holds the result.
- In MIDIENDO, each closing edge adds the period counter to the accumulator (width CNT_W+N_PER_LOG2) and restarts the period counter at 0. After 2^N_PER_LOG2 closed periods the FSM goes to LISTO with periodo_us = accumulator >> N_PER_LOG2 (truncating).
- The period counter saturates at 2^CNT_W−1 and never wraps.
- Timeout: if the period counter reaches TIMEOUT_US in ARMADO or MIDIENDO, the FSM goes to LISTO with timeout_err=1 and periodo_us=0. ARMADO uses its own µs counter for this check.
- LISTO: periodo_valido=1. On ack it goes to REPOSO. If ack and iniciar arrive in the same cycle it goes directly to ARMADO.
- iniciar is ignored in ARMADO and MIDIENDO. ack is ignored outside LISTO. flanco_pos is ignored in REPOSO and LISTO.
- Tick and edge in the same cycle: the tick is counted first, then the period closes with the incremented value.
- Edge in the same cycle as the timeout threshold: the edge wins and the period closes normally.

## Timing
- Reset (async, active-low) forces REPOSO. All outputs reset to 0, as do all counters and the accumulator. Reset mid-measurement discards the partial result.
- periodo_valido and periodo_us are registered. They assert in the cycle after the closing edge or the timeout cycle.
- periodo_valido deasserts in the cycle after ack.
- ocupado asserts in the cycle after iniciar is accepted.
- Tick: one-cycle strobe every TICK_DIV cycles, phase-aligned to the edge that enters MIDIENDO. Quantization error is under 1 µs per period.

## Configuration
- PERIODO_PROMEDIO_EN defined: averaging over 2^N_PER_LOG2 periods, as described above.
- Not defined: the measurement ends after one period. periodo_us equals the raw period count, and the accumulator and shift are removed.

## Structure
- Shared package: FSM state enum (REPOSO, ARMADO, MIDIENDO, LISTO) and the default constants TICK_DIV, CNT_W and TIMEOUT_US.
- One sub-module, base_tiempo_us: prescaler with synchronous clear, producing the µs tick strobe.

## Test plan
- TICK_DIV=50; iniciar, then edges every 50000 cycles (averaging off) -> periodo_us=1000, timeout_err=0, periodo_valido one cycle after the 2nd edge.
- Averaging on, N_PER_LOG2=2, periods 1000/1002/1000/1002 µs -> periodo_us=1001 after the 5th edge.
- TIMEOUT_US=2000, iniciar with no edges -> after 2000 µs periodo_valido=1, timeout_err=1, periodo_us=0.
- Reset asserted mid-MIDIENDO -> all outputs 0, state REPOSO; a later iniciar with 500 µs periods -> periodo_us=500.
- iniciar pulsed during MIDIENDO is ignored (result unchanged). ack and iniciar in the same cycle in LISTO -> periodo_valido drops next cycle, ocupado=1.
- Edge coincident with a tick -> period includes that tick (e.g. 1000, not 999).

Source files
------------

// File: rtl/controlador_periodo_pkg.sv
// controlador_periodo_pkg
// Shared definitions for the period-measurement controller:
//   - estado_t : FSM state encoding (REPOSO, ARMADO, MIDIENDO, LISTO)
//   - default constants for the tick divider, counter width, timeout and
//     averaging depth (the top module exposes them as overridable parameters)
package controlador_periodo_pkg;

  typedef enum logic [1:0] {
    REPOSO   = 2'd0,
    ARMADO   = 2'd1,
    MIDIENDO = 2'd2,
    LISTO    = 2'd3
  } estado_t;

  localparam int TICK_DIV_DEF   = 50;       // clock_FPGA cycles per us (50 MHz)
  localparam int CNT_W_DEF      = 24;       // period / result width in us
  localparam int TIMEOUT_US_DEF = 1000000;  // us without an edge before abort
  localparam int N_PER_LOG2_DEF = 2;        // log2 of periods averaged

endpackage

// File: rtl/controlador_periodo_base_tiempo_us.sv
// base_tiempo_us
// Microsecond timebase: a down-counting prescaler that emits a one-cycle
// tick strobe every TICK_DIV cycles. A synchronous clear reloads the
// prescaler so the first tick lands exactly TICK_DIV cycles after the clear.
// Ports:
//   clock_FPGA  in   system clock
//   reset       in   asynchronous, active-low reset
//   clr         in   synchronous clear (phase realignment)
//   tick        out  one-cycle strobe, once per us
module base_tiempo_us
  import controlador_periodo_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic clock_FPGA,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] CARGA = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;

  always_comb begin
    tick    = 1'b0;
    presc_d = presc_q;
    if (clr) begin
      presc_d = CARGA;
    end else if (presc_q == '0) begin
      tick    = 1'b1;
      presc_d = CARGA;
    end else begin
      presc_d = presc_q - PW'(1);
    end
  end

  always_ff @(posedge clock_FPGA or negedge reset) begin
    if (!reset) presc_q <= '0;
    else        presc_q <= presc_d;
  end

endmodule

// File: rtl/controlador_periodo.sv
// controlador_periodo
// Sequences square-wave period measurement: arms on iniciar, waits for the
// first rising edge, counts us ticks between successive edges and presents
// the result through a valid/ack handshake. Owns the us timebase.
//
// Optional feature macro: PERIODO_PROMEDIO_EN
//   defined   -> result is the truncated average of 2^N_PER_LOG2 periods
//   undefined -> measurement ends after one period (raw count)
//
// Ports:
//   clock_FPGA      in   system clock
//   reset           in   asynchronous, active-low reset
//   flanco_pos      in   single-cycle rising-edge pulse
//   iniciar         in   start request pulse
//   ack             in   consumer acknowledges the result
//   periodo_us      out  measured (average) period in us
//   periodo_valido  out  result available, held until ack
//   timeout_err     out  result is a timeout (qualified by periodo_valido)
//   ocupado         out  high while armed or measuring
//
// state    | meaning
// ---------+-----------------------------------------------------------
// REPOSO   | idle, waits for iniciar
// ARMADO   | waits for the first edge; own us down-timer for timeout
// MIDIENDO | counts us ticks; each edge closes one period
// LISTO    | holds the result until ack
module controlador_periodo
  import controlador_periodo_pkg::*;
#(
  parameter int TICK_DIV   = TICK_DIV_DEF,
  parameter int CNT_W      = CNT_W_DEF,
`ifdef PERIODO_PROMEDIO_EN
  parameter int N_PER_LOG2 = N_PER_LOG2_DEF,
`endif
  parameter int TIMEOUT_US = TIMEOUT_US_DEF
) (
  input  logic             clock_FPGA,
  input  logic             reset,
  input  logic             flanco_pos,
  input  logic             iniciar,
  input  logic             ack,
  output logic [CNT_W-1:0] periodo_us,
  output logic             periodo_valido,
  output logic             timeout_err,
  output logic             ocupado
);

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT_US);

  estado_t          estado_q, estado_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] armado_q, armado_d;
  logic [CNT_W-1:0] periodo_q, periodo_d;
  logic             valido_q, valido_d;
  logic             timeout_q, timeout_d;
  logic             tick;
  logic             clr_base;
  logic [CNT_W-1:0] cnt_inc;

`ifdef PERIODO_PROMEDIO_EN
  localparam int ACC_W = CNT_W + N_PER_LOG2;
  localparam logic [N_PER_LOG2:0] RESTO_INI = (N_PER_LOG2 + 1)'((1 << N_PER_LOG2) - 1);

  logic [ACC_W-1:0]    acc_q, acc_d, acc_sum;
  logic [N_PER_LOG2:0] resto_q, resto_d;

  assign acc_sum = acc_q + ACC_W'(cnt_inc);
`endif

  base_tiempo_us #(
    .TICK_DIV(TICK_DIV)
  ) u_base_tiempo_us (
    .clock_FPGA(clock_FPGA),
    .reset     (reset),
    .clr       (clr_base),
    .tick      (tick)
  );

  // Tick is counted before a coincident edge closes the period; the counter
  // sticks at full scale instead of wrapping.
  assign cnt_inc = (tick && (cnt_q != CNT_MAX)) ? cnt_q + CNT_W'(1) : cnt_q;

  always_comb begin
    estado_d  = estado_q;
    cnt_d     = cnt_q;
    armado_d  = armado_q;
    periodo_d = periodo_q;
    valido_d  = valido_q;
    timeout_d = timeout_q;
    clr_base  = 1'b0;
`ifdef PERIODO_PROMEDIO_EN
    acc_d     = acc_q;
    resto_d   = resto_q;
`endif

    case (estado_q)
      REPOSO: begin
        if (iniciar) begin
          estado_d = ARMADO;
          clr_base = 1'b1;
          armado_d = TIMEOUT_V;
        end
      end

      ARMADO: begin
        if (flanco_pos) begin
          estado_d = MIDIENDO;
          clr_base = 1'b1;
          cnt_d    = '0;
`ifdef PERIODO_PROMEDIO_EN
          acc_d    = '0;
          resto_d  = RESTO_INI;
`endif
        end else if (tick && (armado_q != '0)) begin
          armado_d = armado_q - CNT_W'(1);
          if (armado_q == CNT_W'(1)) begin
            estado_d  = LISTO;
            valido_d  = 1'b1;
            timeout_d = 1'b1;
            periodo_d = '0;
          end
        end
      end

      MIDIENDO: begin
        cnt_d = cnt_inc;
        // An edge on the threshold cycle wins over the timeout.
        if (flanco_pos) begin
          cnt_d = '0;
`ifdef PERIODO_PROMEDIO_EN
          acc_d = acc_sum;
          if (resto_q == '0) begin
            estado_d  = LISTO;
            valido_d  = 1'b1;
            timeout_d = 1'b0;
            periodo_d = CNT_W'(acc_sum >> N_PER_LOG2);
          end else begin
            resto_d = resto_q - (N_PER_LOG2 + 1)'(1);
          end
`else
          estado_d  = LISTO;
          valido_d  = 1'b1;
          timeout_d = 1'b0;
          periodo_d = cnt_inc;
`endif
        end else if (cnt_inc >= TIMEOUT_V) begin
          estado_d  = LISTO;
          valido_d  = 1'b1;
          timeout_d = 1'b1;
          periodo_d = '0;
        end
      end

      LISTO: begin
        if (ack) begin
          valido_d  = 1'b0;
          timeout_d = 1'b0;
          if (iniciar) begin
            estado_d = ARMADO;
            clr_base = 1'b1;
            armado_d = TIMEOUT_V;
          end else begin
            estado_d = REPOSO;
          end
        end
      end

      default: estado_d = REPOSO;
    endcase
  end

  always_ff @(posedge clock_FPGA or negedge reset) begin
    if (!reset) begin
      estado_q  <= REPOSO;
      cnt_q     <= '0;
      armado_q  <= '0;
      periodo_q <= '0;
      valido_q  <= 1'b0;
      timeout_q <= 1'b0;
`ifdef PERIODO_PROMEDIO_EN
      acc_q     <= '0;
      resto_q   <= '0;
`endif
    end else begin
      estado_q  <= estado_d;
      cnt_q     <= cnt_d;
      armado_q  <= armado_d;
      periodo_q <= periodo_d;
      valido_q  <= valido_d;
      timeout_q <= timeout_d;
`ifdef PERIODO_PROMEDIO_EN
      acc_q     <= acc_d;
      resto_q   <= resto_d;
`endif
    end
  end

  assign periodo_us     = periodo_q;
  assign periodo_valido = valido_q;
  assign timeout_err    = timeout_q;
  assign ocupado        = (estado_q == ARMADO) || (estado_q == MIDIENDO);

endmodule

// File: tb/tb_controlador_periodo.sv
// tb_controlador_periodo
// Directed bench for controlador_periodo with a cycle-arithmetic reference
// model (ticks counted as floor(elapsed/TICK_DIV) since the phase-alignment
// point) checked every cycle, plus hand-computed literal expectations.
// Works with and without PERIODO_PROMEDIO_EN.
module tb_controlador_periodo;

  localparam int T   = 5;      // small divider keeps the run short
  localparam int CW  = 24;
  localparam int TO  = 2000;
`ifdef PERIODO_PROMEDIO_EN
  localparam int NPER = 4;
`else
  localparam int NPER = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flanco_pos, iniciar, ack;
  logic [CW-1:0] periodo_us;
  logic          periodo_valido, timeout_err, ocupado;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  controlador_periodo #(
    .TICK_DIV  (T),
    .CNT_W     (CW),
`ifdef PERIODO_PROMEDIO_EN
    .N_PER_LOG2(2),
`endif
    .TIMEOUT_US(TO)
  ) dut (
    .clock_FPGA    (clk),
    .reset         (rst_n),
    .flanco_pos    (flanco_pos),
    .iniciar       (iniciar),
    .ack           (ack),
    .periodo_us    (periodo_us),
    .periodo_valido(periodo_valido),
    .timeout_err   (timeout_err),
    .ocupado       (ocupado)
  );

  task automatic comprobar(input string nombre, input longint act, input longint esp);
    checks++;
    if (act != esp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nombre, act, esp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // fase: 0 idle, 1 waiting first edge, 2 measuring, 3 result held
  longint cyc, ref_c, last_c, m_sum;
  int     m_fase, m_n;
  bit     m_valid, m_to;
  longint m_per;

  task automatic m_fin(input bit to, input longint per);
    m_fase  = 3;
    m_valid = 1'b1;
    m_to    = to;
    m_per   = per;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0; ref_c = 0; last_c = 0; m_sum = 0;
      m_fase = 0; m_n = 0; m_valid = 0; m_to = 0; m_per = 0;
    end else begin
      longint p;
      cyc++;
      case (m_fase)
        0: if (iniciar) begin m_fase = 1; ref_c = cyc; end
        1: begin
          if (flanco_pos) begin
            m_fase = 2; ref_c = cyc; last_c = cyc; m_sum = 0; m_n = 0;
          end else if ((cyc - ref_c) / T >= TO) begin
            m_fin(1'b1, 0);
          end
        end
        2: begin
          p = (cyc - ref_c) / T - (last_c - ref_c) / T;
          if (flanco_pos) begin
            m_sum += p; m_n++; last_c = cyc;
            if (m_n == NPER) m_fin(1'b0, m_sum / NPER);
          end else if (p >= TO) begin
            m_fin(1'b1, 0);
          end
        end
        default: begin
          if (ack) begin
            m_valid = 1'b0;
            m_to    = 1'b0;
            if (iniciar) begin m_fase = 1; ref_c = cyc; end
            else m_fase = 0;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      comprobar("valido_vs_modelo", periodo_valido, m_valid);
      comprobar("ocupado_vs_modelo", ocupado, (m_fase == 1 || m_fase == 2));
      if (m_valid) begin
        comprobar("periodo_vs_modelo", periodo_us, m_per);
        comprobar("timeout_vs_modelo", timeout_err, m_to);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic espera(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulso_iniciar();
    iniciar = 1'b1; espera(1); iniciar = 1'b0;
  endtask

  task automatic pulso_ack(input bit con_iniciar);
    ack = 1'b1; iniciar = con_iniciar; espera(1); ack = 1'b0; iniciar = 1'b0;
  endtask

  task automatic pulso_flanco();
    flanco_pos = 1'b1; espera(1); flanco_pos = 1'b0;
  endtask

  // Next edge is sampled exactly 'gap' cycles after the previous one.
  task automatic flanco_tras(input int gap, input bit con_iniciar);
    if (con_iniciar) begin
      espera(gap / 2);
      pulso_iniciar();
      espera(gap - 2 - gap / 2);
    end else begin
      espera(gap - 1);
    end
    pulso_flanco();
  endtask

  task automatic esperar_valido(input int max, output int n);
    n = 0;
    while (!periodo_valido && n < max) begin
      espera(1);
      n++;
    end
    if (!periodo_valido) comprobar("espera_valido_agotada", 0, 1);
  endtask

  initial begin
    int n;
    int gaps1[4] = '{5000, 5010, 5000, 5010};
    rst_n = 1'b0; flanco_pos = 1'b0; iniciar = 1'b0; ack = 1'b0;
    espera(3);
    comprobar("reset_valido", periodo_valido, 0);
    comprobar("reset_periodo", periodo_us, 0);
    comprobar("reset_timeout", timeout_err, 0);
    comprobar("reset_ocupado", ocupado, 0);
    rst_n = 1'b1;
    espera(2);

    // Edge spacing of 5000 cycles lands on a tick: 1000 us, not 999.
    // iniciar pulses during the measurement must be ignored.
    pulso_iniciar();
    comprobar("ocupado_tras_iniciar", ocupado, 1);
    espera(5);
    pulso_flanco();
    for (int i = 0; i < NPER; i++) begin
      flanco_tras(gaps1[i], (i % 2) == 0);
      if (i == NPER - 1) comprobar("valido_ciclo_tras_flanco", periodo_valido, 1);
      else               comprobar("sin_valido_intermedio", periodo_valido, 0);
    end
`ifdef PERIODO_PROMEDIO_EN
    comprobar("periodo_promedio", periodo_us, 1001);
`else
    comprobar("periodo_1000", periodo_us, 1000);
`endif
    comprobar("sin_timeout", timeout_err, 0);
    pulso_ack(1'b0);
    comprobar("valido_baja_tras_ack", periodo_valido, 0);
    comprobar("reposo_tras_ack", ocupado, 0);
    espera(4);

    // Timeout while armed: valid exactly TO*T cycles after iniciar is taken.
    pulso_iniciar();
    esperar_valido(TO * T + 50, n);
    comprobar("ciclos_hasta_timeout", n, TO * T);
    comprobar("timeout_err", timeout_err, 1);
    comprobar("timeout_periodo_cero", periodo_us, 0);

    // ack + iniciar together: straight back to armed.
    pulso_ack(1'b1);
    comprobar("ack_ini_valido", periodo_valido, 0);
    comprobar("ack_ini_ocupado", ocupado, 1);

    // Edge one cycle before a tick: that tick is not counted (499, not 500).
    espera(3);
    pulso_flanco();
    for (int i = 0; i < NPER; i++) flanco_tras(2499, 1'b0);
    comprobar("periodo_499", periodo_us, 499);
    pulso_ack(1'b0);
    espera(3);

    // Reset mid-measurement, then a clean 500 us measurement.
    pulso_iniciar();
    espera(2);
    pulso_flanco();
    espera(3000);
    rst_n = 1'b0;
    espera(1);
    comprobar("rst_medio_valido", periodo_valido, 0);
    comprobar("rst_medio_ocupado", ocupado, 0);
    comprobar("rst_medio_periodo", periodo_us, 0);
    comprobar("rst_medio_timeout", timeout_err, 0);
    rst_n = 1'b1;
    espera(2);
    comprobar("reposo_tras_rst", ocupado, 0);
    pulso_iniciar();
    espera(2);
    pulso_flanco();
    for (int i = 0; i < NPER; i++) flanco_tras(2500, 1'b0);
    comprobar("periodo_500", periodo_us, 500);
    pulso_ack(1'b0);
    espera(3);

    // Edge on the exact timeout threshold: the edge wins.
    pulso_iniciar();
    espera(2);
    pulso_flanco();
    flanco_tras(TO * T, 1'b0);
    esperar_valido(TO * T + 100, n);
`ifdef PERIODO_PROMEDIO_EN
    comprobar("umbral_luego_timeout", timeout_err, 1);
    comprobar("umbral_luego_periodo", periodo_us, 0);
`else
    comprobar("umbral_flanco_gana_to", timeout_err, 0);
    comprobar("umbral_flanco_gana_per", periodo_us, TO);
`endif
    pulso_ack(1'b0);
    espera(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
